// File: rtl/button_encoder_pkg.sv
// Shared types and defaults for the push-button encoder.
// Holds the FSM state type, default parameters and the saturating counter helper.
package button_encoder_pkg;

  localparam int unsigned NBUTTONS_DEF        = 20;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 3;
  localparam int unsigned CNT_W               = 4;
  localparam int unsigned CODE_W              = 5;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pb_sync.sv
// Two-flop synchronizer for a vector of asynchronous levels.
// Both stages are cleared by a synchronous active-high reset.
module pb_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/button_encoder.sv
// Debounced push-button encoder: reports the highest pressed index once per press,
// with a one-cycle strobe and a held flag until the release has settled.
module button_encoder
  import button_encoder_pkg::*;
#(
  parameter int unsigned NBUTTONS        = NBUTTONS_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                hz100,
  input  logic                reset,
  input  logic [NBUTTONS-1:0] pb,
  output logic [CODE_W-1:0]   code,
  output logic                strobe,
  output logic                held
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NBUTTONS-1:0] sv;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NBUTTONS-1:0] cand_q, cand_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                strobe_q, strobe_d;
  logic                accept;
  logic [CODE_W-1:0]   prio_idx;

  pb_sync #(
    .WIDTH(NBUTTONS)
  ) u_sync (
    .clk_i(hz100),
    .rst_i(reset),
    .d_i  (pb),
    .q_o  (sv)
  );

  // Later (higher) indices overwrite earlier ones, so the highest set bit wins.
  always_comb begin
    prio_idx = '0;
    for (int unsigned i = 0; i < NBUTTONS; i++) begin
      if (cand_q[i]) prio_idx = CODE_W'(i);
    end
  end

  always_ff @(posedge hz100) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sv != '0) begin
          cand_d  = sv;
          cnt_d   = '0;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (sv == '0) begin
          state_d = IDLE;
        end else if (sv != cand_q) begin
          cand_d = sv;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          accept  = 1'b1;
          state_d = PRESSED;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      PRESSED: begin
        if (sv == '0) begin
          cnt_d   = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (sv != '0) begin
          cnt_d   = '0;
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    code_d   = accept ? prio_idx : code_q;
    strobe_d = accept;
    held     = (state_q == PRESSED) || (state_q == RELEASE);
  end

  always_ff @(posedge hz100) begin
    if (reset) begin
      code_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      code_q   <= code_d;
      strobe_q <= strobe_d;
    end
  end

  assign code   = code_q;
  assign strobe = strobe_q;

endmodule

// File: tb/tb_button_encoder.sv
// Scoreboard bench for button_encoder: a run-length reference model predicts accepted
// presses, a negedge monitor compares strobe/code/held against it every cycle.
module tb_button_encoder;

  localparam int unsigned NB = 20;
  localparam int unsigned DC = 3;

  logic          hz100 = 1'b0;
  logic          reset;
  logic [NB-1:0] pb;
  logic [4:0]    code;
  logic          strobe;
  logic          held;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;
  int unsigned strobe_cnt = 0;

  button_encoder #(
    .NBUTTONS       (NB),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .hz100 (hz100),
    .reset (reset),
    .pb    (pb),
    .code  (code),
    .strobe(strobe),
    .held  (held)
  );

  always #5 hz100 = ~hz100;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned top_index(input logic [NB-1:0] v);
    for (int i = NB - 1; i >= 0; i--) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  // Reference model: a press is accepted once the synchronized vector has shown the same
  // nonzero value for DC+1 samples while armed; it re-arms after DC+1 consecutive zero samples.
  logic [NB-1:0] m_s1 = '0, m_s2 = '0, m_last = '0, m_sv;
  int unsigned   m_run = 0;
  bit            m_armed = 1'b1;
  bit            m_strobe = 1'b0;
  int unsigned   m_code = 0;
  int unsigned   exp_q[$];

  always @(posedge hz100) begin
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_last = '0;
      m_run = 0; m_armed = 1'b1; m_strobe = 1'b0; m_code = 0;
    end else begin
      m_sv = m_s2;
      m_s2 = m_s1;
      m_s1 = pb;
      if (m_sv == m_last) begin
        if (m_run < 1000) m_run++;
      end else begin
        m_last = m_sv;
        m_run  = 1;
      end
      m_strobe = 1'b0;
      if (m_armed) begin
        if (m_sv != '0 && m_run == DC + 1) begin
          m_armed  = 1'b0;
          m_strobe = 1'b1;
          m_code   = top_index(m_sv);
          exp_q.push_back(m_code);
        end
      end else if (m_sv == '0 && m_run == DC + 1) begin
        m_armed = 1'b1;
      end
    end
  end

  always @(negedge hz100) begin
    chk("strobe", 32'(strobe), 32'(m_strobe));
    chk("held", 32'(held), 32'(!m_armed));
    chk("code", 32'(code), m_code);
    if (strobe === 1'b1) begin
      strobe_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", 32'(strobe), 32'd0);
      end else begin
        chk("strobe_code", 32'(code), exp_q.pop_front());
      end
    end
  end

  task automatic drive(input logic [NB-1:0] v, input int unsigned n);
    repeat (n) begin
      pb = v;
      @(negedge hz100);
    end
  endtask

  task automatic do_reset(input int unsigned n);
    reset = 1'b1;
    repeat (n) @(negedge hz100);
    reset = 1'b0;
  endtask

  function automatic logic [NB-1:0] bit_of(input int unsigned i);
    logic [NB-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  initial begin
    int unsigned base;
    logic [NB-1:0] v;
    pb    = '0;
    reset = 1'b1;
    repeat (3) @(negedge hz100);
    reset = 1'b0;

    // Single press, long hold
    base = strobe_cnt;
    drive(bit_of(12), 10);
    drive('0, 10);
    chk("r027_strobes", strobe_cnt - base, 1);
    chk("r027_code", 32'(code), 12);

    // Bouncing input never accepted
    do_reset(2);
    base = strobe_cnt;
    for (int unsigned i = 0; i < 20; i++) drive((i % 2 == 0) ? bit_of(3) : '0, 1);
    drive('0, 10);
    chk("r028_strobes", strobe_cnt - base, 0);
    chk("r028_code", 32'(code), 0);

    // Simultaneous press, then partial release
    base = strobe_cnt;
    drive(bit_of(4) | bit_of(17), 10);
    drive(bit_of(4), 10);
    drive('0, 10);
    chk("r029_strobes", strobe_cnt - base, 1);
    chk("r029_code", 32'(code), 17);

    // Long hold, release, press again
    base = strobe_cnt;
    drive(bit_of(5), 50);
    drive('0, 10);
    drive(bit_of(5), 10);
    drive('0, 10);
    chk("r030_strobes", strobe_cnt - base, 2);
    chk("r030_code", 32'(code), 5);

    // Reset during debounce
    base = strobe_cnt;
    drive(bit_of(9), 3);
    chk("r031_pre_strobes", strobe_cnt - base, 0);
    pb = bit_of(9);
    do_reset(1);
    chk("r031_code_after_reset", 32'(code), 0);
    drive(bit_of(9), 10);
    drive('0, 10);
    chk("r031_strobes", strobe_cnt - base, 1);
    chk("r031_code", 32'(code), 9);

    // Short release glitch returns to pressed
    base = strobe_cnt;
    drive(bit_of(2), 10);
    drive('0, 2);
    drive(bit_of(2), 10);
    drive('0, 10);
    chk("r032_strobes", strobe_cnt - base, 1);

    // Randomized segments
    for (int unsigned s = 0; s < 400; s++) begin
      if ($urandom_range(0, 39) == 0) begin
        do_reset(1);
      end else begin
        case ($urandom_range(0, 5))
          0, 1:    v = '0;
          2, 3:    v = bit_of($urandom_range(0, NB - 1));
          4:       v = bit_of($urandom_range(0, NB - 1)) | bit_of($urandom_range(0, NB - 1));
          default: v = NB'($urandom);
        endcase
        drive(v, $urandom_range(1, 7));
      end
    end
    drive('0, 12);
    chk("pending_strobes", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/button_encoder.md
BUTTON_ENCODER -- requirements
Module: button_encoder

Interface
REQ-001 SHALL have parameter NBUTTONS, default 20, number of push-button inputs encoded.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 3, consecutive stable clocks required to accept a press or release (legal range 1..15).
REQ-003 SHALL have port hz100  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port pb  input  NBUTTONS  raw asynchronous button levels, 1 = pressed.
REQ-006 SHALL have port code  output  5  index of the most recently accepted button.
REQ-007 SHALL have port strobe  output  1  one-cycle pulse marking a newly accepted press.
REQ-008 SHALL have port held  output  1  high while an accepted press has not yet been released.

Function
REQ-009 SHALL pass pb through a two-flop synchronizer; all further logic uses only the synchronized vector (sv).
REQ-010 SHALL implement FSM states IDLE, DEBOUNCE, PRESSED, RELEASE.
REQ-011 IDLE: sv == 0 stays IDLE; sv != 0 captures sv as candidate, clears counter, goes DEBOUNCE.
REQ-012 DEBOUNCE: sv == candidate increments counter; sv differs and is nonzero recaptures candidate and clears counter; sv == 0 returns to IDLE with no output change.
REQ-013 DEBOUNCE: when counter reaches DEBOUNCE_CYCLES-1 with sv == candidate, SHALL load code with the highest set index of candidate, pulse strobe for exactly one clock, go PRESSED.
REQ-014 Latency: pb stable from edge k produces strobe high in the cycle following edge k+2+DEBOUNCE_CYCLES.
REQ-015 PRESSED: held = 1; any nonzero sv (including added/changed buttons) stays PRESSED with no new strobe; sv == 0 clears counter, goes RELEASE.
REQ-016 RELEASE: held = 1; sv stays 0 for DEBOUNCE_CYCLES consecutive clocks goes IDLE with held = 0; any nonzero sv returns to PRESSED and clears counter.
REQ-017 Simultaneous buttons: priority SHALL be highest index; code width 5 covers indices 0..NBUTTONS-1.
REQ-018 code SHALL hold its value until the next accepted press; it is not cleared on release.
REQ-019 strobe SHALL never be high on two consecutive cycles; holding a button SHALL never auto-repeat.
REQ-020 Counter SHALL saturate and never wrap; width is 4 bits.

Reset
REQ-021 reset high at a clock edge SHALL force state IDLE, counter 0, candidate 0, synchronizer flops 0, code 0, strobe 0, held 0.
REQ-022 reset asserted mid-debounce or while PRESSED SHALL abort without strobe; a button still held after reset deasserts SHALL be re-debounced and accepted as a new press.
REQ-023 reset has priority over every other input in the same cycle.

Structure
REQ-024 Shared package SHALL hold the state enum typedef and the NBUTTONS/DEBOUNCE_CYCLES defaults.
REQ-025 Synchronizer SHALL be a separate sub-module pb_sync (parameterized width, two flops, synchronous reset).
REQ-026 Priority encoder SHALL be combinational logic inside button_encoder; no latches; all registers in one clocked block per concern.

Verification
REQ-027 pb[12] pressed steady 10 cycles after reset -> exactly one strobe 5 cycles after press (DEBOUNCE_CYCLES=3), code = 12, held = 1 until release settles.
REQ-028 pb[3] toggles every cycle for 20 cycles, then 0 -> strobe never asserts, code stays 0, held stays 0.
REQ-029 pb[4] and pb[17] pressed same cycle -> one strobe, code = 17; later releasing only pb[17] -> no new strobe.
REQ-030 pb[5] held 50 cycles, released, pb[5] pressed again -> two strobes total, code = 5 both times, held low between.
REQ-031 pb[9] pressed, reset pulsed one cycle during DEBOUNCE -> no strobe before reset, code = 0 after reset, one strobe with code = 9 five cycles after reset deasserts.
REQ-032 pb[2] accepted, released for 2 cycles, re-pressed -> no second strobe (RELEASE returns to PRESSED), held stays 1.
